// File: rtl/kplic_gateway.sv
// kplic_gateway: per-source interrupt gateway (sync, edge/level qualify, IDLE/PENDING/IN_SERVICE FSM).
// Optional macro KPLIC_EDGE_QUEUE_EN adds a 2-bit queue of extra rising edges per edge-type source.
`default_nettype none

module kplic_gateway #(
   parameter int INT_NUM    = 32,
   parameter int INT_WIDTH  = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  kplic_clk,
   input  logic                  kplic_rstn,
   input  logic [INT_NUM-1:0]    int_src,
   input  logic [DATA_WIDTH-1:0] int_type,
   input  logic [DATA_WIDTH-1:0] int_enable,
   input  logic                  int_claim,
   input  logic [INT_WIDTH-1:0]  mppi,
   input  logic [INT_NUM-1:0]    int_completion,
   output logic [DATA_WIDTH-1:0] int_pending_status,
   output logic [INT_NUM-1:0]    int_in_service
);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_PENDING    = 2'd1;
   localparam logic [1:0] ST_IN_SERVICE = 2'd2;

   logic [INT_NUM-1:0] sync1_q, sync2_q, sync3_q;
   logic [INT_NUM-1:0] rise;
   logic [INT_NUM-1:0] pend;

   always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
      if (!kplic_rstn) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= int_src;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   assign rise = sync2_q & ~sync3_q;

   for (genvar i = 0; i < INT_NUM; i++) begin : g_src
      logic [1:0] state_q, state_d;
      logic       claim_hit;
      logic       trigger;
      logic       requeue;

      // mppi values >= INT_NUM never equal any i, so out-of-range claims fall through
      assign claim_hit = int_claim && (32'(mppi) == i);
      assign trigger   = int_enable[i] && (int_type[i] ? rise[i] : sync2_q[i]);

`ifdef KPLIC_EDGE_QUEUE_EN
      logic [1:0] cnt_q, cnt_d;
      logic       edge_q, edge_d;
      logic       inc, dec, clr;

      assign inc     = edge_q && rise[i] &&
                       (state_q == ST_PENDING || state_q == ST_IN_SERVICE);
      // An edge landing on the completion cycle re-pends directly instead of being counted
      assign dec     = (state_q == ST_IN_SERVICE) && int_completion[i] &&
                       (cnt_q != 2'd0 || inc);
      assign clr     = !int_enable[i] && (state_q == ST_IDLE || state_q == ST_PENDING);
      assign requeue = dec;

      always_comb begin
         edge_d = edge_q;
         if (state_q == ST_IDLE) edge_d = int_type[i];
         cnt_d = cnt_q;
         if (clr)
            cnt_d = 2'd0;
         else if (inc && !dec && cnt_q != 2'd3)
            cnt_d = cnt_q + 2'd1;
         else if (dec && !inc)
            cnt_d = cnt_q - 2'd1;
      end

      always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
         if (!kplic_rstn) begin
            cnt_q  <= 2'd0;
            edge_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            edge_q <= edge_d;
         end
      end
`else
      assign requeue = 1'b0;
`endif

      always_comb begin
         state_d = state_q;
         case (state_q)
            ST_IDLE:       if (trigger) state_d = ST_PENDING;
            ST_PENDING: begin
               if (!int_enable[i])  state_d = ST_IDLE;
               else if (claim_hit)  state_d = ST_IN_SERVICE;
            end
            ST_IN_SERVICE: if (int_completion[i]) state_d = requeue ? ST_PENDING : ST_IDLE;
            default:       state_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge kplic_clk or negedge kplic_rstn) begin
         if (!kplic_rstn) state_q <= ST_IDLE;
         else             state_q <= state_d;
      end

      assign pend[i]           = (state_q == ST_PENDING);
      assign int_in_service[i] = (state_q == ST_IN_SERVICE);
   end

   if (DATA_WIDTH > INT_NUM) begin : g_pad
      logic unused_hi_bits;
      assign unused_hi_bits     = ^{int_type[DATA_WIDTH-1:INT_NUM], int_enable[DATA_WIDTH-1:INT_NUM]};
      assign int_pending_status = {{(DATA_WIDTH-INT_NUM){1'b0}}, pend};
   end else begin : g_nopad
      assign int_pending_status = pend;
   end

endmodule

`default_nettype wire

// File: doc/kplic_gateway.md
Name: kplic_gateway

Overview:
Per-source interrupt gateway sitting between the external interrupt pins and kplic_core. It consumes the int_type, int_enable, int_completion and int_claim controls from the KPLIC register block. Each source has a synchronizer, an edge/level qualifier and a small state machine. The block produces the pending vector that kplic_core arbitrates and that software reads back as int_pending_status.

Parameters:
INT_NUM, 32, number of interrupt sources (1..32)
INT_WIDTH, 5, width of an interrupt ID
DATA_WIDTH, 32, register data width

Ports:
kplic_clk  in  1  KPLIC clock; the only clock in the block
kplic_rstn  in  1  KPLIC reset, asynchronous, active-low
int_src  in  INT_NUM  raw asynchronous interrupt sources
int_type  in  DATA_WIDTH  per-source type: 1 = edge-triggered, 0 = level-sensitive
int_enable  in  DATA_WIDTH  per-source enable: 1 = enabled
int_claim  in  1  single-cycle claim pulse (read of the MPPI register)
mppi  in  INT_WIDTH  ID being claimed; valid when int_claim = 1
int_completion  in  INT_NUM  one-hot completion pulse
int_pending_status  out  DATA_WIDTH  per-source pending vector to kplic_core and the register block
int_in_service  out  INT_NUM  per-source "claimed, awaiting completion" flags

Behaviour:
- Clocking and reset:
  - One clock, kplic_clk.
  - Reset kplic_rstn is asynchronous assert, active-low.
  - On reset, all flops clear: synchronizers 0, every source in IDLE, int_pending_status = 0, int_in_service = 0.
- Input conditioning:
  - Each int_src bit passes through a 2-flop synchronizer (s1, s2).
  - A third flop s3 holds the previous s2.
  - level_i = s2[i]; rise_i = s2[i] & ~s3[i].
- Per-source FSM states: IDLE, PENDING, IN_SERVICE.
- IDLE -> PENDING when int_enable[i] = 1 and the trigger is met:
  - trigger = rise_i if int_type[i] = 1;
  - trigger = level_i if int_type[i] = 0.
- PENDING -> IN_SERVICE when int_claim = 1 and mppi == i.
- PENDING -> IDLE when int_enable[i] = 0. The pending request is dropped; this takes priority over a same-cycle claim.
- IN_SERVICE -> IDLE when int_completion[i] = 1. Enable changes do not affect IN_SERVICE.
- Rules in other states:
  - A claim is ignored unless the source is PENDING.
  - A completion is ignored unless the source is IN_SERVICE.
  - Claim and completion for the same source therefore never conflict.
  - A claim with mppi >= INT_NUM is ignored.
- Outputs:
  - int_pending_status[i] = 1 iff the source is PENDING.
  - int_in_service[i] = 1 iff the source is IN_SERVICE.
  - Bits INT_NUM..DATA_WIDTH-1 of int_pending_status are tied to 0.
  - Both outputs are registered (decoded directly from state flops).
- Latency:
  - int_src[i] stable high before clock edge k gives int_pending_status[i] = 1 after edge k+2, for both edge and level types.
  - A claim pulse at edge k clears pending and sets in_service after edge k.
- Level sources:
  - Once PENDING, the request stays latched even if the source deasserts.
  - After completion, if level_i is still high, the source goes IDLE for one cycle and then back to PENDING.
- Edge sources: without the optional feature, rising edges seen while PENDING or IN_SERVICE are discarded.
- int_type[i] changes are sampled only in IDLE and never alter a request already in flight.
- Reset mid-operation: all sources return to IDLE immediately; lost requests are not recovered.

Optional Feature:
- Macro: KPLIC_EDGE_QUEUE_EN.
- When defined:
  - Each edge-type source has a 2-bit saturating counter (max 3) of rising edges seen while PENDING or IN_SERVICE.
  - On completion, if the count is > 0, the source goes IN_SERVICE -> PENDING directly and the count decrements.
  - The counter clears on reset, and when int_enable[i] = 0 while the source is IDLE or PENDING.
  - The counter is not used for level sources.
- When undefined: no counters exist, and extra edges are dropped as described above.

Test Plan:
- Level source 3, int_type = 0, enable = 1: hold int_src[3] high from edge 10 → int_pending_status = 0x8 after edge 12. Claim with mppi = 3 → pending 0, int_in_service[3] = 1. Complete 3 with source still high → pending 0x8 again two cycles after completion.
- Edge source 5, int_type[5] = 1: 3-cycle pulse on int_src[5] → pending 0x20 remains after the pulse ends. Claim, then complete → pending 0, in_service 0.
- Source 7 PENDING, drop int_enable[7] in the same cycle as claim with mppi = 7 → source goes IDLE, in_service[7] = 0.
- Claim with mppi = 9 while source 9 is IDLE, and completion of 2 while source 2 is PENDING → no state change anywhere.
- KPLIC_EDGE_QUEUE_EN defined: edge source 4, claimed, 4 further edges arrive, then 4 completions → source 4 re-pends after the first 3 completions only (count saturated at 3). Without the macro → no re-pend.
- Reset asserted while sources 1 and 2 are PENDING/IN_SERVICE → both outputs 0 immediately, with no pending after release until a new trigger.
